// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus: decode-side inputs and execute-side registered outputs.
interface id_ex_pipe_reg_if #(
  parameter int unsigned NB_DATA       = 32,
  parameter int unsigned NB_REG        = 5,
  parameter int unsigned NB_FUNCTION   = 6,
  parameter int unsigned NB_ALU_OP     = 3,
  parameter int unsigned NB_REG_DST    = 2,
  parameter int unsigned NB_BUBBLE_CNT = 16
);
  // Sequencing / hazard controls
  logic                     i_enable;
  logic                     i_bubble;
  logic                     i_flush;
  logic                     i_valid;
  // Decode-stage payload
  logic [NB_DATA-1:0]       i_pc_plus4;
  logic [NB_DATA-1:0]       i_rs_data;
  logic [NB_DATA-1:0]       i_rt_data;
  logic [NB_DATA-1:0]       i_imm;
  logic [NB_REG-1:0]        i_rs;
  logic [NB_REG-1:0]        i_rt;
  logic [NB_REG-1:0]        i_rd;
  logic [NB_REG-1:0]        i_shamt;
  logic [NB_FUNCTION-1:0]   i_function;
  logic [NB_ALU_OP-1:0]     i_alu_op;
  logic                     i_alu_src;
  logic                     i_mem_read;
  logic                     i_mem_write;
  logic                     i_reg_write;
  logic                     i_mem_to_reg;
  logic                     i_jal;
  logic [NB_REG_DST-1:0]    i_reg_dst;
  // Execute-stage registered copies
  logic [NB_DATA-1:0]       o_pc_plus4;
  logic [NB_DATA-1:0]       o_rs_data;
  logic [NB_DATA-1:0]       o_rt_data;
  logic [NB_DATA-1:0]       o_imm;
  logic [NB_REG-1:0]        o_rs;
  logic [NB_REG-1:0]        o_rt;
  logic [NB_REG-1:0]        o_rd;
  logic [NB_REG-1:0]        o_shamt;
  logic [NB_FUNCTION-1:0]   o_function;
  logic [NB_ALU_OP-1:0]     o_alu_op;
  logic                     o_alu_src;
  logic                     o_mem_read;
  logic                     o_mem_write;
  logic                     o_reg_write;
  logic                     o_mem_to_reg;
  logic                     o_jal;
  logic [NB_REG_DST-1:0]    o_reg_dst;
  logic                     o_valid;
  logic [NB_BUBBLE_CNT-1:0] o_bubble_count;

  // Decode side: drives the payload, observes the registered stage
  modport master (
    output i_enable, i_bubble, i_flush, i_valid,
           i_pc_plus4, i_rs_data, i_rt_data, i_imm,
           i_rs, i_rt, i_rd, i_shamt, i_function, i_alu_op,
           i_alu_src, i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg, i_jal,
           i_reg_dst,
    input  o_pc_plus4, o_rs_data, o_rt_data, o_imm,
           o_rs, o_rt, o_rd, o_shamt, o_function, o_alu_op,
           o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg, o_jal,
           o_reg_dst, o_valid, o_bubble_count
  );

  // Pipeline register side
  modport slave (
    input  i_enable, i_bubble, i_flush, i_valid,
           i_pc_plus4, i_rs_data, i_rt_data, i_imm,
           i_rs, i_rt, i_rd, i_shamt, i_function, i_alu_op,
           i_alu_src, i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg, i_jal,
           i_reg_dst,
    output o_pc_plus4, o_rs_data, o_rt_data, o_imm,
           o_rs, o_rt, o_rd, o_shamt, o_function, o_alu_op,
           o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg, o_jal,
           o_reg_dst, o_valid, o_bubble_count
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with debug freeze, NOP injection on bubble/flush,
// and a saturating count of injected NOPs.
module id_ex_pipe_reg #(
  parameter int unsigned NB_DATA       = 32,
  parameter int unsigned NB_REG        = 5,
  parameter int unsigned NB_FUNCTION   = 6,
  parameter int unsigned NB_ALU_OP     = 3,
  parameter int unsigned NB_REG_DST    = 2,
  parameter int unsigned NB_BUBBLE_CNT = 16
) (
  input  logic           i_clock,
  input  logic           i_reset,
  id_ex_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic [NB_DATA-1:0]     pc_plus4;
    logic [NB_DATA-1:0]     rs_data;
    logic [NB_DATA-1:0]     rt_data;
    logic [NB_DATA-1:0]     imm;
    logic [NB_REG-1:0]      rs;
    logic [NB_REG-1:0]      rt;
    logic [NB_REG-1:0]      rd;
    logic [NB_REG-1:0]      shamt;
    logic [NB_FUNCTION-1:0] funct;
    logic [NB_ALU_OP-1:0]   alu_op;
    logic                   alu_src;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   jal;
    logic [NB_REG_DST-1:0]  reg_dst;
  } payload_t;

  localparam logic [NB_BUBBLE_CNT-1:0] CNT_MAX = '1;

  payload_t                 payload_d;
  payload_t                 payload_q;
  logic                     valid_q;
  logic [NB_BUBBLE_CNT-1:0] bubble_cnt_q;
  logic                     nop_c;

  // Gather decode fields into one payload word
  always_comb begin
    payload_d            = '0;
    payload_d.pc_plus4   = bus.i_pc_plus4;
    payload_d.rs_data    = bus.i_rs_data;
    payload_d.rt_data    = bus.i_rt_data;
    payload_d.imm        = bus.i_imm;
    payload_d.rs         = bus.i_rs;
    payload_d.rt         = bus.i_rt;
    payload_d.rd         = bus.i_rd;
    payload_d.shamt      = bus.i_shamt;
    payload_d.funct      = bus.i_function;
    payload_d.alu_op     = bus.i_alu_op;
    payload_d.alu_src    = bus.i_alu_src;
    payload_d.mem_read   = bus.i_mem_read;
    payload_d.mem_write  = bus.i_mem_write;
    payload_d.reg_write  = bus.i_reg_write;
    payload_d.mem_to_reg = bus.i_mem_to_reg;
    payload_d.jal        = bus.i_jal;
    payload_d.reg_dst    = bus.i_reg_dst;
  end

  // Flush and bubble both collapse into a single NOP per edge
  assign nop_c = bus.i_flush | bus.i_bubble;

  // Stage register: freeze when disabled, NOP on hazard, otherwise capture
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      payload_q    <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else if (bus.i_enable) begin
      if (nop_c) begin
        payload_q <= '0;
        valid_q   <= 1'b0;
        if (bubble_cnt_q != CNT_MAX) begin
          bubble_cnt_q <= bubble_cnt_q + NB_BUBBLE_CNT'(1);
        end
      end else begin
        payload_q <= payload_d;
        valid_q   <= bus.i_valid;
      end
    end
  end

  // Outputs are straight flop copies
  assign bus.o_pc_plus4     = payload_q.pc_plus4;
  assign bus.o_rs_data      = payload_q.rs_data;
  assign bus.o_rt_data      = payload_q.rt_data;
  assign bus.o_imm          = payload_q.imm;
  assign bus.o_rs           = payload_q.rs;
  assign bus.o_rt           = payload_q.rt;
  assign bus.o_rd           = payload_q.rd;
  assign bus.o_shamt        = payload_q.shamt;
  assign bus.o_function     = payload_q.funct;
  assign bus.o_alu_op       = payload_q.alu_op;
  assign bus.o_alu_src      = payload_q.alu_src;
  assign bus.o_mem_read     = payload_q.mem_read;
  assign bus.o_mem_write    = payload_q.mem_write;
  assign bus.o_reg_write    = payload_q.reg_write;
  assign bus.o_mem_to_reg   = payload_q.mem_to_reg;
  assign bus.o_jal          = payload_q.jal;
  assign bus.o_reg_dst      = payload_q.reg_dst;
  assign bus.o_valid        = valid_q;
  assign bus.o_bubble_count = bubble_cnt_q;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Pipeline register between Instruction Decode and Execute.
- Captures decoded operands, register indices, ALU control fields (ALU op code, function field) and downstream control bits at the clock edge. Presents them to the Execute stage: ALU-control unit, ALU operand muxes, forwarding unit.
- Supports debug-unit stepping (enable), load-use bubble insertion and branch/jump flush.
- Keeps a saturating bubble counter readable by the debug unit.

Parameters:
- NB_DATA, 32, width of data/PC/immediate fields
- NB_REG, 5, width of register index and shamt fields
- NB_FUNCTION, 6, width of R-type function field
- NB_ALU_OP, 3, width of ALU op code from main control
- NB_REG_DST, 2, width of destination-select field (rt/rd/r31)
- NB_BUBBLE_CNT, 16, width of bubble counter

Ports:
- i_clock  in  1  system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  debug-unit step/run enable; 0 = freeze everything
- i_bubble  in  1  hazard unit load-use request: insert NOP
- i_flush  in  1  branch/jump taken: kill instruction in ID
- i_valid  in  1  instruction in ID is valid
- i_pc_plus4  in  NB_DATA  PC+4 of ID instruction
- i_rs_data, i_rt_data  in  NB_DATA each  register-file read data
- i_imm  in  NB_DATA  sign/zero-extended immediate
- i_rs, i_rt, i_rd, i_shamt  in  NB_REG each  instruction fields
- i_function  in  NB_FUNCTION  R-type function field
- i_alu_op  in  NB_ALU_OP  ALU op code from main control
- i_alu_src, i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg, i_jal  in  1 each  control bits
- i_reg_dst  in  NB_REG_DST  destination select
- o_* (one per i_ data/control field above, same width)  out  registered copy
- o_valid  out  1  registered instruction valid
- o_bubble_count  out  NB_BUBBLE_CNT  NOPs injected since reset

Behaviour:
- Reset (i_reset=0, asynchronous, immediate): every output 0, including o_valid and o_bubble_count. Outputs stay 0 while reset is held. First capture is at the first rising edge after release.
- Per-edge priority:
  - i_enable=0: hold all state. Bubble/flush are ignored; the counter does not change.
  - Else i_flush=1 or i_bubble=1: load NOP. All data, index, function and ALU-op fields become 0, all control bits 0, o_valid=0. o_bubble_count increments by 1 (once per edge even if both asserted) and saturates at all-ones.
  - Else: load every o_* from its i_* counterpart. o_valid=i_valid.
- Latency: exactly 1 cycle, input sampled at edge N and visible after edge N.
- No combinational input-to-output path; all outputs come straight from flops.
- An invalid load (i_valid=0, no flush/bubble) still copies fields. Downstream must qualify writes with o_valid. Control bits pass through unmodified.
- NOP encoding: o_alu_op=0, o_function=0, o_reg_write=0, o_mem_write=0, o_mem_read=0. It must not write the register file or memory.
- Counter saturation: at all-ones, further bubbles leave it unchanged, with no wrap.
- Reset asserted mid-stall or mid-flush: outputs clear immediately, with no pending state retained.

Test Plan:
- Reset then load i_rs_data=0x0000_0005, i_rt_data=0xFFFF_FFFD, i_function=6'h21, i_alu_op=3'b000, i_reg_write=1, i_valid=1 -> after one edge, outputs equal inputs, o_valid=1, o_bubble_count=0.
- Load a valid instruction, then pulse i_bubble for 1 cycle with new inputs present -> next edge all outputs 0, o_valid=0, o_bubble_count=1; the following edge loads normally.
- i_flush=1 and i_bubble=1 same cycle -> single NOP, o_bubble_count increments by exactly 1.
- i_enable=0 for 3 cycles while inputs change and i_flush toggles -> outputs and counter unchanged. On i_enable=1 the next edge captures the current inputs.
- Preload the counter to 0xFFFE via repeated bubbles (or use NB_BUBBLE_CNT=2 build: 3 bubbles -> 3), then 2 more bubbles -> stays 0xFFFF (or 3).
- Drive i_reset=0 asynchronously mid-cycle between edges with o_valid=1, o_bubble_count=7 -> all outputs 0 before the next clock edge.
